// File: rtl/snake_game_pkg.sv
// Shared types and constants for the snake game flow controller:
// state encoding, PS/2 set-2 key codes and the mode-output decode.
package snake_game_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DEAD  = 3'd4
  } state_e;

  localparam logic [KEY_W-1:0] KEY_NONE  = 8'h00;
  localparam logic [KEY_W-1:0] KEY_START = 8'h5A;
  localparam logic [KEY_W-1:0] KEY_PAUSE = 8'h4D;
  localparam logic [KEY_W-1:0] KEY_ESC   = 8'h76;
  localparam logic [KEY_W-1:0] KEY_UP    = 8'h75;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 8'h72;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 8'h6B;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 8'h74;

  typedef struct packed {
    logic init_snake;
    logic screen_black;
    logic screen_pause;
  } mode_t;

  function automatic logic is_arrow(input logic [KEY_W-1:0] k);
    return (k == KEY_UP) || (k == KEY_DOWN) || (k == KEY_LEFT) || (k == KEY_RIGHT);
  endfunction

  // Illegal encodings decode like IDLE so the screen stays blank while recovering.
  function automatic mode_t decode_mode(input state_e s);
    mode_t m;
    case (s)
      ST_INIT:  m = '{init_snake: 1'b1, screen_black: 1'b0, screen_pause: 1'b1};
      ST_RUN:   m = '{init_snake: 1'b0, screen_black: 1'b0, screen_pause: 1'b0};
      ST_PAUSE: m = '{init_snake: 1'b0, screen_black: 1'b0, screen_pause: 1'b1};
      ST_DEAD:  m = '{init_snake: 1'b0, screen_black: 1'b0, screen_pause: 1'b1};
      default:  m = '{init_snake: 1'b1, screen_black: 1'b1, screen_pause: 1'b1};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_key_sync.sv
// Input conditioning: two-register key_code stabiliser (valid when both
// stages agree) and a 2-flop synchroniser for the Vsync-domain died flag.
module key_sync
  import snake_game_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_died,
  input  logic [KEY_W-1:0] i_key_code,
  output logic             o_key_valid_c,
  output logic [KEY_W-1:0] o_key,
  output logic             o_died_s
);

  logic [KEY_W-1:0] r_k1;
  logic [KEY_W-1:0] r_k2;
  logic             r_died_s1;
  logic             r_died_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k1      <= '0;
      r_k2      <= '0;
      r_died_s1 <= 1'b0;
      r_died_s2 <= 1'b0;
    end else begin
      r_k1      <= i_key_code;
      r_k2      <= r_k1;
      r_died_s1 <= i_died;
      r_died_s2 <= r_died_s1;
    end
  end

  // A code still settling across the PS2Clk boundary shows up as k1 != k2.
  assign o_key_valid_c = (r_k1 == r_k2);
  assign o_key         = r_k2;
  assign o_died_s      = r_died_s2;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-flow FSM for the VGA snake game: IDLE/INIT/RUN/PAUSE/DEAD driving
// init_snake, screen_black and screen_pause. Optional SNAKE_GAME_CTRL_AUTO_RESTART_EN.
module snake_game_ctrl
  import snake_game_pkg::*;
#(
  parameter int unsigned INIT_CYCLES      = 2_000_000,
  parameter int unsigned DEAD_HOLD_CYCLES = 300_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             died,
  input  logic [KEY_W-1:0] key_code,
  output logic             init_snake,
  output logic             screen_black,
  output logic             screen_pause
);

`ifdef SNAKE_GAME_CTRL_AUTO_RESTART_EN
  localparam bit AUTO_RESTART = 1'b1;
`else
  localparam bit AUTO_RESTART = 1'b0;
`endif

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_HOLD_CYCLES - 1);

  logic             w_key_valid;
  logic [KEY_W-1:0] w_key_raw;
  logic [KEY_W-1:0] w_key;
  logic             w_died_s;
  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  mode_t            r_mode;

  key_sync u_key_sync (
    .clk           (clk),
    .reset         (reset),
    .i_died        (died),
    .i_key_code    (key_code),
    .o_key_valid_c (w_key_valid),
    .o_key         (w_key_raw),
    .o_died_s      (w_died_s)
  );

  assign w_key = w_key_valid ? w_key_raw : KEY_NONE;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state; ESC override is applied last so it beats every other exit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_key == KEY_START) w_next = ST_INIT;
      ST_INIT:  if (r_cnt == INIT_LAST) w_next = ST_RUN;
      ST_RUN: begin
        if (w_died_s)                w_next = ST_DEAD;
        else if (w_key == KEY_PAUSE) w_next = ST_PAUSE;
      end
      ST_PAUSE: if (is_arrow(w_key)) w_next = ST_RUN;
      ST_DEAD: begin
        if (w_key == KEY_START)                      w_next = ST_INIT;
        else if (AUTO_RESTART && (r_cnt == DEAD_LAST)) w_next = ST_INIT;
      end
      default:  w_next = ST_IDLE;
    endcase
    if (w_key == KEY_ESC) w_next = ST_IDLE;
  end

  // Dwell counter: restarts on every state change, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)                  r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (r_cnt != '1)       r_cnt <= r_cnt + CNT_W'(1);
  end

  // Outputs track the state register on the same edge.
  always_ff @(posedge clk) begin
    if (reset) r_mode <= '{init_snake: 1'b1, screen_black: 1'b1, screen_pause: 1'b1};
    else       r_mode <= decode_mode(w_next);
  end

  assign init_snake   = r_mode.init_snake;
  assign screen_black = r_mode.screen_black;
  assign screen_pause = r_mode.screen_pause;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl; outputs checked as {init,black,pause}.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       died;
  logic [7:0] key_code;
  logic       init_snake;
  logic       screen_black;
  logic       screen_pause;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [2:0] M_IDLE  = 3'b111;
  localparam logic [2:0] M_INIT  = 3'b101;
  localparam logic [2:0] M_RUN   = 3'b000;
  localparam logic [2:0] M_PAUSE = 3'b001;
  localparam logic [2:0] M_DEAD  = 3'b001;

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .INIT_CYCLES      (10),
    .DEAD_HOLD_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .died         (died),
    .key_code     (key_code),
    .init_snake   (init_snake),
    .screen_black (screen_black),
    .screen_pause (screen_pause)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_mode(input string tag, input logic [2:0] exp);
    logic [2:0] got;
    got = {init_snake, screen_black, screen_pause};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a key after a falling edge: old mode two edges later, new mode on the third.
  task automatic key_and_check(input string tag, input logic [7:0] k,
                               input logic [2:0] old_m, input logic [2:0] new_m);
    key_code = k;
    step(2);
    check_mode({tag, "_pre"}, old_m);
    step(1);
    check_mode(tag, new_m);
  endtask

  initial begin
    reset    = 1'b1;
    died     = 1'b0;
    key_code = 8'h00;
    step(2);
    check_mode("reset", M_IDLE);
    reset = 1'b0;
    step(100);
    check_mode("idle_hold", M_IDLE);

    // IDLE -> INIT -> RUN after exactly 10 cycles of INIT
    key_and_check("start", 8'h5A, M_IDLE, M_INIT);
    step(9);
    check_mode("init_last", M_INIT);
    step(1);
    check_mode("run", M_RUN);

    // START still held in RUN; pause, resume, held pause
    step(5);
    check_mode("start_held_run", M_RUN);
    key_and_check("pause", 8'h4D, M_RUN, M_PAUSE);
    key_and_check("resume_up", 8'h75, M_PAUSE, M_RUN);
    key_and_check("pause2", 8'h4D, M_RUN, M_PAUSE);
    step(50);
    check_mode("pause_held", M_PAUSE);
    key_and_check("resume_down", 8'h72, M_PAUSE, M_RUN);

    // died and PAUSE together: died wins
    died = 1'b1;
    key_and_check("died_wins", 8'h4D, M_RUN, M_DEAD);
    key_and_check("dead_arrow", 8'h74, M_DEAD, M_DEAD);
    key_and_check("dead_start", 8'h5A, M_DEAD, M_INIT);
    died = 1'b0;
    step(10);
    check_mode("run_after_dead", M_RUN);

    // ESC from RUN, PAUSE, DEAD, INIT
    key_and_check("esc_run", 8'h76, M_RUN, M_IDLE);
    key_and_check("start2", 8'h5A, M_IDLE, M_INIT);
    step(10);
    check_mode("run2", M_RUN);
    key_and_check("pause3", 8'h4D, M_RUN, M_PAUSE);
    key_and_check("esc_pause", 8'h76, M_PAUSE, M_IDLE);
    key_and_check("start3", 8'h5A, M_IDLE, M_INIT);
    step(10);
    check_mode("run3", M_RUN);
    key_code = 8'h00;
    died     = 1'b1;
    step(2);
    check_mode("died_pre", M_RUN);
    step(1);
    check_mode("dead", M_DEAD);
    died = 1'b0;
    key_and_check("esc_dead", 8'h76, M_DEAD, M_IDLE);
    key_and_check("start4", 8'h5A, M_IDLE, M_INIT);
    key_and_check("esc_init", 8'h76, M_INIT, M_IDLE);

    // Reset mid-INIT aborts the count; a fresh INIT runs its full length
    key_and_check("start5", 8'h5A, M_IDLE, M_INIT);
    step(3);
    reset    = 1'b1;
    key_code = 8'h00;
    step(1);
    check_mode("reset_mid_init", M_IDLE);
    reset = 1'b0;
    key_and_check("start6", 8'h5A, M_IDLE, M_INIT);
    step(9);
    check_mode("init_full_len", M_INIT);
    step(1);
    check_mode("run4", M_RUN);

    // DEAD with no keys: auto restart or permanent hold
    key_and_check("no_key_run", 8'h00, M_RUN, M_RUN);
    died = 1'b1;
    step(3);
    check_mode("dead2", M_DEAD);
    died = 1'b0;
`ifdef SNAKE_GAME_CTRL_AUTO_RESTART_EN
    step(19);
    check_mode("dead_hold_last", M_DEAD);
    step(1);
    check_mode("auto_restart", M_INIT);
`else
    step(1000);
    check_mode("dead_hold", M_DEAD);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Top-level game-flow controller for the VGA snake game.
- Runs on the 100 MHz system clock. Takes the PS/2 "last key pressed" code and the playfield's `died` flag.
- Drives the three mode signals consumed by the snake datapath and renderer: `init_snake`, `screen_black` and `screen_pause`.
- Sits beside the keyboard decoder and the VGA display block in the top level.

Parameters:
- INIT_CYCLES, 2_000_000, number of clk cycles `init_snake` is held in INIT. Must exceed one 60 Hz frame, because the datapath samples it on Vsync.
- DEAD_HOLD_CYCLES, 300_000_000, clk cycles spent in DEAD before automatic restart. Used only with the optional feature.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- died  in  1  snake collided or left the field; asynchronous to clk (Vsync domain)
- key_code  in  8  PS/2 set-2 code of the last key pressed; level-held, PS2Clk domain
- init_snake  out  1  hold snake and score at their initial values
- screen_black  out  1  renderer outputs the blank/title colour instead of the playfield
- screen_pause  out  1  freeze snake movement

Behaviour:
- Input sync:
  - `died` passes through a 2-flop synchroniser.
  - `key_code` is registered twice (k1, k2). A key is valid only when k1 == k2; otherwise the keys are treated as "none" for that cycle.
- Key map:
  - START = 8'h5A (Enter)
  - PAUSE = 8'h4D (P)
  - ESC = 8'h76
  - ARROWS = 8'h75, 8'h72, 8'h6B, 8'h74
- States, with a 3-bit encoding:
  - IDLE = 0
  - INIT = 1
  - RUN = 2
  - PAUSE = 3
  - DEAD = 4
- Transitions, evaluated every clk:
  - Any state, valid ESC -> IDLE. This has priority over every other transition.
  - IDLE: START -> INIT.
  - INIT: counter runs from 0; when it reaches INIT_CYCLES-1 -> RUN. `died` and keys other than ESC are ignored.
  - RUN:
    - synced `died` = 1 -> DEAD.
    - else PAUSE key -> PAUSE.
    - `died` wins if both occur in the same cycle.
  - PAUSE: any ARROW -> RUN. `died` is ignored.
  - DEAD: START -> INIT.
- Level-key semantics: `key_code` is held, so each state reacts only to codes that leave it.
  - Example: START still present in RUN has no effect.
  - PAUSE held while in PAUSE keeps the block paused.
- Outputs are registered and decoded from the state register; they change on the same edge as the state.

  | State | init_snake | screen_black | screen_pause |
  |---|---|---|---|
  | IDLE | 1 | 1 | 1 |
  | INIT | 1 | 0 | 1 |
  | RUN | 0 | 0 | 0 |
  | PAUSE | 0 | 0 | 1 |
  | DEAD | 0 | 0 | 1 |

- Reset:
  - State goes to IDLE; outputs are 1, 1, 1.
  - Synchronisers clear to 0 and the counter clears to 0.
  - A reset asserted mid-INIT aborts the INIT count.
- Latency: a key_code change that is stable before edge N causes the state/output change at edge N+2. A `died` rising before edge N causes the change at edge N+2.
- Counter:
  - 32-bit; cleared on every state entry.
  - Saturates at its maximum; it never wraps.
- Illegal state encodings (5..7) recover to IDLE on the next clk.

Optional Feature:
- Macro: SNAKE_GAME_CTRL_AUTO_RESTART_EN.
- When defined: DEAD also exits to INIT once the counter reaches DEAD_HOLD_CYCLES-1. START still exits earlier, and ESC still wins.
- When not defined: DEAD is left only via START or ESC, and DEAD_HOLD_CYCLES is unused.

Decomposition:
- Package snake_game_pkg holds:
  - the state typedef/encoding;
  - the key-code constants START, PAUSE, ESC, UP, DOWN, LEFT, RIGHT.
- One natural sub-module, key_sync: the 2-register `key_code` stabiliser plus the `died` 2-flop synchroniser, which outputs key_valid, key, died_s.
- The FSM, counter and output decode live in snake_game_ctrl.

Test Plan:
1. Reset for 2 cycles with key_code = 8'h00 -> outputs (1,1,1) and they stay unchanged for 100 cycles.
2. key_code = 8'h5A from IDLE, INIT_CYCLES overridden to 10 -> outputs become (1,0,1) at edge +2, then (0,0,0) exactly 10 cycles later.
3. In RUN, key_code = 8'h4D -> (0,0,1) at +2. Next, key_code = 8'h75 -> (0,0,0) at +2. Then key_code = 8'h4D held for 50 cycles -> stays (0,0,1).
4. In RUN, raise `died` and key_code = 8'h4D in the same cycle -> DEAD (0,0,1). Then key_code = 8'h5A -> INIT (1,0,1).
5. From each of RUN, PAUSE and DEAD, key_code = 8'h76 -> (1,1,1) at +2. Reset asserted mid-INIT -> IDLE on the next edge.
6. With SNAKE_GAME_CTRL_AUTO_RESTART_EN and DEAD_HOLD_CYCLES = 20, no keys -> INIT after 20 cycles. Without the macro -> still DEAD after 1000 cycles.
